// File: rtl/prng_sample_buffer.sv
// prng_sample_buffer: consumes an 8-bit PRNG byte stream. After reset or clr_alarm
// it discards WARMUP samples. It runs a repetition-count health test on every sample
// and queues healthy samples in a first-word-fall-through FIFO, which is read through
// a valid/ready port.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid, in_data     upstream sample strobe and byte (no backpressure)
//   out_valid, out_ready  FIFO non-empty / consumer accept
//   out_data              FIFO head, zero while empty
//   fifo_level            number of entries stored
//   dropped               one-cycle pulse when a healthy sample is lost to a full FIFO
//   alarm                 sticky health-test failure
//   clr_alarm             leave the alarm state and restart warm-up
module prng_sample_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WARMUP    = 16,
    parameter int unsigned REP_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [7:0]                   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_data,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         dropped,
    output logic                         alarm,
    input  logic                         clr_alarm
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
    localparam int unsigned WARM_W = $clog2(WARMUP + 1);
    localparam int unsigned REP_W  = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_ALARM  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic [REP_W-1:0]    rep_calc;
    logic [7:0]          prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic [PTR_W-1:0]    rd_q, rd_d;
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic [LVL_W-1:0]    level_d;
    logic                out_valid_d;
    logic [7:0]          out_data_d;
    logic [7:0]          head_d;
    logic                dropped_d;
    logic                alarm_d;
    logic                push_req;
    logic                push_en;
    logic                pop;
    logic                trip;
    logic                fifo_full;

    logic [7:0]          mem [DEPTH];

    // Next-state, health test and FIFO control
    always_comb begin
        state_d     = state_q;
        warm_d      = warm_q;
        rep_d       = rep_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        level_d     = fifo_level;
        push_req    = 1'b0;
        push_en     = 1'b0;
        pop         = 1'b0;
        trip        = 1'b0;
        dropped_d   = 1'b0;
        fifo_full   = (fifo_level == LVL_W'(DEPTH));

        // Repeat run length including the current sample, saturating at the limit
        if (prev_vld_q && (in_data == prev_q)) begin
            rep_calc = (rep_q == REP_W'(REP_LIMIT)) ? rep_q : rep_q + REP_W'(1);
        end else begin
            rep_calc = REP_W'(1);
        end

        case (state_q)
            ST_WARMUP: begin
                if (in_valid) begin
                    rep_d      = rep_calc;
                    prev_d     = in_data;
                    prev_vld_d = 1'b1;
                    if (rep_calc == REP_W'(REP_LIMIT)) begin
                        trip = 1'b1;
                    end else begin
                        warm_d = warm_q + WARM_W'(1);
                        if (warm_q == WARM_W'(WARMUP - 1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    rep_d      = rep_calc;
                    prev_d     = in_data;
                    prev_vld_d = 1'b1;
                    if (rep_calc == REP_W'(REP_LIMIT)) begin
                        trip = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
            end
            ST_ALARM: begin
                if (clr_alarm) begin
                    state_d    = ST_WARMUP;
                    warm_d     = '0;
                    rep_d      = '0;
                    prev_vld_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_WARMUP;
            end
        endcase

        if (trip) begin
            // Flush overrides any pop or push in the tripping cycle
            state_d = ST_ALARM;
            rd_d    = '0;
            wr_d    = '0;
            level_d = '0;
        end else begin
            pop       = out_valid && out_ready;
            push_en   = push_req && (!fifo_full || pop);
            dropped_d = push_req && !push_en;
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            if (push_en) begin
                wr_d = wr_q + PTR_W'(1);
            end
            case ({push_en, pop})
                2'b10:   level_d = fifo_level + LVL_W'(1);
                2'b01:   level_d = fifo_level - LVL_W'(1);
                default: level_d = fifo_level;
            endcase
        end

        // Registered FWFT head: a push landing at the new read pointer is the new head
        if (push_en && (wr_q == rd_d)) begin
            head_d = in_data;
        end else begin
            head_d = mem[rd_d];
        end
        out_valid_d = (level_d != '0);
        out_data_d  = out_valid_d ? head_d : 8'h00;
        alarm_d     = (state_d == ST_ALARM);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_WARMUP;
            warm_q     <= '0;
            rep_q      <= '0;
            prev_q     <= 8'h00;
            prev_vld_q <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            dropped    <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_q     <= warm_d;
            rep_q      <= rep_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            fifo_level <= level_d;
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            dropped    <= dropped_d;
            alarm      <= alarm_d;
        end
    end

    // Sample storage; contents are only read while the matching entry is live
    always_ff @(posedge clk) begin
        if (rst_n && push_en) begin
            mem[wr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_prng_sample_buffer.sv
module tb_prng_sample_buffer;

    localparam int DEPTH     = 4;
    localparam int WARMUP    = 16;
    localparam int REP_LIMIT = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] fifo_level;
    logic       dropped;
    logic       alarm;
    logic       clr_alarm;

    int n_checks = 0;
    int n_errors = 0;

    prng_sample_buffer #(
        .DEPTH(DEPTH), .WARMUP(WARMUP), .REP_LIMIT(REP_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .dropped(dropped), .alarm(alarm),
        .clr_alarm(clr_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: mode 0=warm-up, 1=run, 2=alarm; FIFO as a queue
    int       m_mode;
    int       m_wcnt;
    int       m_run;
    int       m_prev;
    bit       m_have;
    bit       m_drop;
    int       m_q[$];

    task automatic model_reset();
        m_mode = 0; m_wcnt = 0; m_run = 0; m_prev = 0; m_have = 0; m_drop = 0;
        m_q.delete();
    endtask

    task automatic model_step(input bit iv, input int d, input bit rdy, input bit clr, input bit rst);
        bit do_pop;
        if (rst) begin
            model_reset();
            return;
        end
        m_drop = 0;
        do_pop = (m_q.size() > 0) && rdy;
        if (m_mode == 2) begin
            if (clr) begin
                m_mode = 0; m_wcnt = 0; m_run = 0; m_have = 0;
            end
        end else if (iv) begin
            if (m_have && d == m_prev) m_run = (m_run + 1 > REP_LIMIT) ? REP_LIMIT : m_run + 1;
            else m_run = 1;
            m_prev = d;
            m_have = 1;
            if (m_run == REP_LIMIT) begin
                m_mode = 2;
                m_q.delete();
                do_pop = 0;
            end else if (m_mode == 0) begin
                m_wcnt++;
                if (m_wcnt == WARMUP) m_mode = 1;
            end else begin
                if (do_pop) begin
                    void'(m_q.pop_front());
                    do_pop = 0;
                end
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_drop = 1;
            end
        end
        if (do_pop) void'(m_q.pop_front());
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model, then compare all outputs against it
    task automatic step(input bit iv, input int d, input bit rdy, input bit clr, input bit rst);
        in_valid  = iv;
        in_data   = 8'(d);
        out_ready = rdy;
        clr_alarm = clr;
        rst_n     = !rst;
        model_step(iv, d, rdy, clr, rst);
        @(posedge clk);
        #1;
        chk("m_out_valid", int'(out_valid), int'(m_q.size() > 0));
        chk("m_out_data", int'(out_data), (m_q.size() > 0) ? m_q[0] : 0);
        chk("m_fifo_level", int'(fifo_level), m_q.size());
        chk("m_dropped", int'(dropped), int'(m_drop));
        chk("m_alarm", int'(alarm), int'(m_mode == 2));
    endtask

    typedef struct {
        bit iv; int d; bit rdy; bit clr;
        bit ev; int ed; int el; bit edrop; bit ealarm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit iv, input int d, input bit rdy, input bit clr,
                       input bit ev, input int ed, input int el, input bit edrop, input bit ealarm);
        vec_t v;
        v.iv = iv; v.d = d; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.el = el; v.edrop = edrop; v.ealarm = ealarm;
        tbl.push_back(v);
    endtask

    initial begin
        int  d;
        int  last;
        in_valid = 0; in_data = 0; out_ready = 0; clr_alarm = 0; rst_n = 0;
        model_reset();

        // Expected-output table, starting right after a completed warm-up
        //   iv   d     rdy clr | valid data level drop alarm
        add(1, 8'h01, 1, 0,   1, 8'h01, 1, 0, 0);
        add(1, 8'h02, 1, 0,   1, 8'h02, 1, 0, 0);
        add(1, 8'h03, 1, 0,   1, 8'h03, 1, 0, 0);
        add(1, 8'h04, 1, 0,   1, 8'h04, 1, 0, 0);
        add(0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 0);
        add(1, 8'h21, 0, 0,   1, 8'h21, 1, 0, 0);
        add(1, 8'h22, 0, 0,   1, 8'h21, 2, 0, 0);
        add(1, 8'h23, 0, 0,   1, 8'h21, 3, 0, 0);
        add(1, 8'h24, 0, 0,   1, 8'h21, 4, 0, 0);
        add(1, 8'h25, 0, 0,   1, 8'h21, 4, 1, 0);
        add(1, 8'h26, 0, 0,   1, 8'h21, 4, 1, 0);
        add(0, 8'h00, 0, 0,   1, 8'h21, 4, 0, 0);
        add(1, 8'h5A, 1, 0,   1, 8'h22, 4, 0, 0);
        add(0, 8'h00, 1, 0,   1, 8'h23, 3, 0, 0);
        add(0, 8'h00, 1, 0,   1, 8'h24, 2, 0, 0);
        add(0, 8'h00, 1, 0,   1, 8'h5A, 1, 0, 0);
        add(0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 0);
        add(1, 8'h31, 0, 0,   1, 8'h31, 1, 0, 0);
        add(1, 8'h32, 0, 0,   1, 8'h31, 2, 0, 0);
        add(1, 8'hA5, 0, 0,   1, 8'h31, 3, 0, 0);
        add(1, 8'hA5, 0, 0,   1, 8'h31, 4, 0, 0);
        add(1, 8'hA5, 0, 0,   1, 8'h31, 4, 1, 0);
        add(1, 8'hA5, 1, 0,   0, 8'h00, 0, 0, 1);
        add(1, 8'h77, 1, 0,   0, 8'h00, 0, 0, 1);
        add(0, 8'h00, 1, 1,   0, 8'h00, 0, 0, 0);

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_alarm", int'(alarm), 0);
        chk("reset_level", int'(fifo_level), 0);

        // Warm-up: 16 distinct samples, nothing emerges even with out_ready high
        for (int i = 0; i < WARMUP; i++) begin
            step(1, 8'h10 + i, 1, 0, 0);
            chk("warmup_no_output", int'(out_valid), 0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].rdy, tbl[i].clr, 0);
            chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i), int'(out_data), tbl[i].ed);
            chk($sformatf("tbl%0d_level", i), int'(fifo_level), tbl[i].el);
            chk($sformatf("tbl%0d_dropped", i), int'(dropped), int'(tbl[i].edrop));
            chk($sformatf("tbl%0d_alarm", i), int'(alarm), int'(tbl[i].ealarm));
        end

        // After clr_alarm: 16 more discarded, the 17th is output
        for (int i = 0; i < WARMUP; i++) begin
            step(1, 8'h50 + i, 0, 0, 0);
            chk("rewarm_no_output", int'(out_valid), 0);
        end
        step(1, 8'h42, 0, 0, 0);
        chk("rewarm_17th_valid", int'(out_valid), 1);
        chk("rewarm_17th_data", int'(out_data), 8'h42);

        // Reset in RUN with level 3
        step(1, 8'h43, 0, 0, 0);
        step(1, 8'h44, 0, 0, 0);
        chk("pre_reset_level", int'(fifo_level), 3);
        step(1, 8'h45, 1, 0, 1);
        chk("mid_reset_level", int'(fifo_level), 0);
        chk("mid_reset_valid", int'(out_valid), 0);
        chk("mid_reset_alarm", int'(alarm), 0);
        for (int i = 0; i < WARMUP; i++) begin
            step(1, 8'h60 + i, 1, 0, 0);
            chk("post_reset_warmup", int'(out_valid), 0);
        end
        step(1, 8'h99, 1, 0, 0);
        chk("post_reset_first_data", int'(out_data), 8'h99);

        // Randomized run against the reference model
        last = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 0) d = $urandom_range(0, 2);
            else d = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) d = last;
            last = d;
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
